silife_grid_port_arbiter: RTL and testbench
===========================================

// Module: silife_grid_port_arbiter
// PURPOSE
//  Shares the single port of the cell-grid memory between two requesters: the MAX7219 display
//  refresher, which reads one WIDTH-bit row per request, and the life engine, which reads and writes rows.
//  Sits between the grid RAM and its clients.
//  - Engine has fixed priority; a starvation counter guarantees the display a slot within MAX_WAIT cycles.
//  - Read data is routed back to the winning requester with a per-requester valid strobe.
// PARAMETERS
//  WIDTH         32  row width in cells (bits per memory word)
//  HEIGHT        32  number of rows; ROW_BITS = $clog2(HEIGHT)
//  READ_LATENCY  1   memory read latency in cycles, legal range 1..3
//  MAX_WAIT      8   max cycles a pending display request may lose before it is forced through (>=1)
// PORTS
//  clk          in   1         system clock
//  reset        in   1         synchronous, active-high
//  disp_req     in   1         display read request; held with disp_row until disp_gnt
//  disp_row     in   ROW_BITS  row to read
//  disp_gnt     out  1         request accepted this cycle (combinational)
//  disp_rvalid  out  1         disp_rdata valid, READ_LATENCY cycles after disp_gnt
//  disp_rdata   out  WIDTH     read data (direct from mem_rdata)
//  eng_req      in   1         engine request; held with eng_we/eng_row/eng_wdata until eng_gnt
//  eng_we       in   1         1 = write eng_wdata to eng_row, 0 = read
//  eng_row      in   ROW_BITS  row address
//  eng_wdata    in   WIDTH     write data
//  eng_gnt      out  1         request accepted this cycle (combinational)
//  eng_rvalid   out  1         eng_rdata valid, READ_LATENCY cycles after a read grant
//  eng_rdata    out  WIDTH     read data (direct from mem_rdata)
//  mem_en       out  1         memory access strobe
//  mem_we       out  1         memory write enable
//  mem_addr     out  ROW_BITS  memory row address
//  mem_wdata    out  WIDTH     memory write data
//  mem_rdata    in   WIDTH     memory read data, valid READ_LATENCY cycles after mem_en&!mem_we
// BEHAVIOUR
//  - Arbitration is combinational, one grant per cycle, no idle cycle between grants.
//    - force = disp_req && (wait_cnt == MAX_WAIT).
//    - eng_gnt = eng_req && !force; disp_gnt = disp_req && (!eng_req || force).
//  - mem_en = disp_gnt|eng_gnt.
//    - mem_we = eng_gnt & eng_we.
//    - mem_addr/mem_wdata come from the granted requester; mem_addr = 0 and mem_wdata = 0 when idle.
//  - wait_cnt: $clog2(MAX_WAIT+1) bits.
//    - Reset to 0; also cleared when disp_gnt or !disp_req.
//    - Incremented when disp_req && !disp_gnt; saturates at MAX_WAIT.
//    - A forced display grant clears it. The engine is then denied for exactly that one cycle.
//  - Read-return tag pipeline: READ_LATENCY stages of {disp_rd, eng_rd}, shifted every cycle.
//    - Stage 0 is loaded with {disp_gnt, eng_gnt & !eng_we}.
//    - disp_rvalid/eng_rvalid = last stage; never both high.
//    - Engine writes produce no rvalid.
//  - Back-to-back grants pipeline fully: one rvalid per granted read, in grant order.
//  - Reset (any cycle, incl. mid-read):
//    - All tags cleared, so no rvalid for in-flight reads.
//    - wait_cnt = 0.
//    - Grant, mem_en and mem_we are gated low during the reset cycle.
//  - Both *_rdata outputs continuously mirror mem_rdata; consumers qualify them with *_rvalid.
//  - Requester protocol violation (changing row before grant) is not detected; the address sampled is the one present at the grant cycle.
// STRUCTURE
//  - Shared package silife_pkg:
//    - localparam for ROW_BITS derivation.
//    - Requester index constants REQ_DISP=0, REQ_ENG=1.
//  - One sub-module, silife_tag_pipe: parameterised-depth shift register of valid tags with synchronous clear.
//  - Arbitration and the starvation counter stay in the top module.
// TESTING
//  - Reset: reset=1 with both req=1 -> all gnt/mem_en/rvalid 0. Release -> eng_gnt=1 first cycle.
//  - Display alone: disp_req=1, disp_row=5.
//    - Expect disp_gnt same cycle, mem_addr=5.
//    - Memory returns 32'hA5A5_0F0F one cycle later -> disp_rvalid=1, disp_rdata=32'hA5A5_0F0F.
//  - Contention: eng_req held high, disp_req high, MAX_WAIT=8.
//    - Engine wins 8 cycles; display granted on 9th, engine denied that cycle.
//    - wait_cnt returns to 0; the pattern repeats every 9 cycles.
//  - Engine write then read of row 31: write 32'hDEAD_BEEF, then read.
//    - The write yields no rvalid; the read yields eng_rvalid with 32'hDEAD_BEEF.
//  - READ_LATENCY=3: alternating disp/eng reads on consecutive cycles.
//    - rvalids alternate exactly 3 cycles later in grant order, never overlapping.
//  - Reset mid-flight: reset asserted 1 cycle after a read grant (READ_LATENCY=2) -> no rvalid ever emitted for that read.

Source files
------------

// File: rtl/silife_pkg.sv
// Shared constants for the cell-grid memory port arbiter: geometry defaults,
// row-address width derivation and requester indices.
package silife_pkg;
  localparam int DEF_WIDTH  = 32;
  localparam int DEF_HEIGHT = 32;

  function automatic int row_bits(input int height);
    return (height > 1) ? $clog2(height) : 1;
  endfunction

  localparam int ROW_BITS = row_bits(DEF_HEIGHT);

  // Bit positions in the read-return tag vector
  localparam int REQ_DISP = 0;
  localparam int REQ_ENG  = 1;
  localparam int NUM_REQ  = 2;
endpackage

// File: rtl/silife_grid_port_arbiter_if.sv
// Bundle of the display, engine and memory-side signals around the arbiter.
// slave = arbiter view, master = clients plus grid RAM.
interface silife_grid_port_arbiter_if
  import silife_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int ROW_BITS = silife_pkg::ROW_BITS
);
  logic                disp_req;
  logic [ROW_BITS-1:0] disp_row;
  logic                disp_gnt;
  logic                disp_rvalid;
  logic [WIDTH-1:0]    disp_rdata;

  logic                eng_req;
  logic                eng_we;
  logic [ROW_BITS-1:0] eng_row;
  logic [WIDTH-1:0]    eng_wdata;
  logic                eng_gnt;
  logic                eng_rvalid;
  logic [WIDTH-1:0]    eng_rdata;

  logic                mem_en;
  logic                mem_we;
  logic [ROW_BITS-1:0] mem_addr;
  logic [WIDTH-1:0]    mem_wdata;
  logic [WIDTH-1:0]    mem_rdata;

  modport slave (
    input  disp_req, disp_row, eng_req, eng_we, eng_row, eng_wdata, mem_rdata,
    output disp_gnt, disp_rvalid, disp_rdata, eng_gnt, eng_rvalid, eng_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output disp_req, disp_row, eng_req, eng_we, eng_row, eng_wdata, mem_rdata,
    input  disp_gnt, disp_rvalid, disp_rdata, eng_gnt, eng_rvalid, eng_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/silife_tag_pipe.sv
// Fixed-depth shift register of read-return tags; a synchronous clear drops
// every in-flight tag so no return strobe survives a reset.
module silife_tag_pipe #(
  parameter int DEPTH = 1,
  parameter int W     = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] tag_in,
  output logic [W-1:0] tag_out
);
  logic [DEPTH-1:0][W-1:0] vld_pipe;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  assign tag_out = vld_pipe[DEPTH-1];
endmodule

// File: rtl/silife_grid_port_arbiter.sv
// Single-port grid RAM arbiter: engine has fixed priority, display is forced
// through after MAX_WAIT lost cycles; read data is steered back by tag.
module silife_grid_port_arbiter
  import silife_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int HEIGHT       = DEF_HEIGHT,
  parameter int READ_LATENCY = 1,
  parameter int MAX_WAIT     = 8
) (
  input logic                      clk,
  input logic                      reset,
  silife_grid_port_arbiter_if.slave bus
);
  localparam int RB        = row_bits(HEIGHT);
  localparam int WAIT_BITS = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_BITS-1:0] WAIT_MAX = WAIT_BITS'(MAX_WAIT);

  logic [WAIT_BITS-1:0] wait_cnt;
  logic                 force_disp;
  logic                 disp_gnt;
  logic                 eng_gnt;
  logic [NUM_REQ-1:0]   tag_in;
  logic [NUM_REQ-1:0]   tag_out;

  // Grants are gated during reset so nothing reaches the RAM that cycle
  assign force_disp = bus.disp_req && (wait_cnt == WAIT_MAX);
  assign eng_gnt    = !reset && bus.eng_req && !force_disp;
  assign disp_gnt   = !reset && bus.disp_req && (!bus.eng_req || force_disp);

  always_ff @(posedge clk) begin
    if (reset || !bus.disp_req || disp_gnt) wait_cnt <= '0;
    else if (wait_cnt != WAIT_MAX)          wait_cnt <= wait_cnt + 1'b1;
  end

  assign bus.disp_gnt  = disp_gnt;
  assign bus.eng_gnt   = eng_gnt;
  assign bus.mem_en    = disp_gnt | eng_gnt;
  assign bus.mem_we    = eng_gnt & bus.eng_we;
  assign bus.mem_addr  = disp_gnt ? bus.disp_row :
                         eng_gnt  ? bus.eng_row  : RB'(0);
  assign bus.mem_wdata = eng_gnt ? bus.eng_wdata : '0;

  always_comb begin
    tag_in           = '0;
    tag_in[REQ_DISP] = disp_gnt;
    tag_in[REQ_ENG]  = eng_gnt & ~bus.eng_we;
  end

  silife_tag_pipe #(.DEPTH(READ_LATENCY), .W(NUM_REQ)) u_tags (
    .clk     (clk),
    .reset   (reset),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  // At most one tag is set per stage since only one grant issues per cycle
  assign bus.disp_rvalid = tag_out[REQ_DISP];
  assign bus.eng_rvalid  = tag_out[REQ_ENG];
  assign bus.disp_rdata  = bus.mem_rdata;
  assign bus.eng_rdata   = bus.mem_rdata;
endmodule

// File: tb/tb_silife_grid_port_arbiter.sv
// Scoreboard bench: three arbiters (READ_LATENCY 1, 3, 2) each with a behavioural RAM;
// directed stimulus pushes expected returns, per-instance monitors pop and compare.
module tb_silife_grid_port_arbiter;
  import silife_pkg::*;

  localparam int N  = 3;
  localparam int W  = 32;
  localparam int RB = silife_pkg::ROW_BITS;

  function automatic int rl_of(input int i);
    case (i)
      0:       return 1;
      1:       return 3;
      default: return 2;
    endcase
  endfunction

  function automatic logic [31:0] init_val(input int g, input int r);
    if (r == 5) return 32'hA5A5_0F0F;
    return {16'hC0DE, 8'(g), 8'(r)};
  endfunction

  typedef struct {
    int          who;
    int          cyc;
    logic [31:0] data;
  } exp_t;

  exp_t sbq [N][$];
  int   nvec = 0;
  int   nmis = 0;
  int   cyc  = 0;
  int   rv_cnt [N];

  logic clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [N-1:0]    rst, d_req, e_req, e_we;
  logic [RB-1:0]   d_row [N];
  logic [RB-1:0]   e_row [N];
  logic [W-1:0]    e_wd  [N];
  logic [N-1:0]    o_dgnt, o_egnt, o_en, o_we, o_drv, o_erv;
  logic [RB-1:0]   o_addr [N];
  logic [W-1:0]    o_wd   [N];

  silife_grid_port_arbiter_if #(.WIDTH(W), .ROW_BITS(RB)) bus [N] ();

  for (genvar g = 0; g < N; g++) begin : gi
    localparam int RL = rl_of(g);
    logic [W-1:0] rp  [RL];
    logic [W-1:0] mem [2**RB];

    assign bus[g].disp_req  = d_req[g];
    assign bus[g].disp_row  = d_row[g];
    assign bus[g].eng_req   = e_req[g];
    assign bus[g].eng_we    = e_we[g];
    assign bus[g].eng_row   = e_row[g];
    assign bus[g].eng_wdata = e_wd[g];
    assign bus[g].mem_rdata = rp[RL-1];
    assign o_dgnt[g] = bus[g].disp_gnt;
    assign o_egnt[g] = bus[g].eng_gnt;
    assign o_en[g]   = bus[g].mem_en;
    assign o_we[g]   = bus[g].mem_we;
    assign o_addr[g] = bus[g].mem_addr;
    assign o_wd[g]   = bus[g].mem_wdata;
    assign o_drv[g]  = bus[g].disp_rvalid;
    assign o_erv[g]  = bus[g].eng_rvalid;

    silife_grid_port_arbiter #(
      .WIDTH(W), .HEIGHT(2**RB), .READ_LATENCY(RL), .MAX_WAIT(8)
    ) dut (
      .clk   (clk),
      .reset (rst[g]),
      .bus   (bus[g])
    );

    // RAM model: access sampled mid-cycle, applied at the clock edge
    initial begin : memmodel
      logic s_en, s_we;
      logic [RB-1:0] s_a;
      logic [W-1:0]  s_d;
      for (int r = 0; r < 2**RB; r++) mem[r] = init_val(g, r);
      for (int k = 0; k < RL; k++) rp[k] = '0;
      forever begin
        @(negedge clk);
        s_en = bus[g].mem_en; s_we = bus[g].mem_we;
        s_a  = bus[g].mem_addr; s_d = bus[g].mem_wdata;
        @(posedge clk);
        for (int k = RL - 1; k > 0; k--) rp[k] = rp[k-1];
        rp[0] = (s_en && !s_we) ? mem[s_a] : '0;
        if (s_en && s_we) mem[s_a] = s_d;
      end
    end

    initial begin : mon
      exp_t e;
      int who;
      logic [31:0] data;
      rv_cnt[g] = 0;
      forever begin
        @(negedge clk);
        if (bus[g].disp_rvalid && bus[g].eng_rvalid) begin
          nvec++; nmis++;
          $display("FAIL dual_rvalid inst%0d cyc %0d: got both rvalid high, required at most one", g, cyc);
        end else if (bus[g].disp_rvalid || bus[g].eng_rvalid) begin
          rv_cnt[g]++;
          who  = bus[g].disp_rvalid ? REQ_DISP : REQ_ENG;
          data = bus[g].disp_rvalid ? bus[g].disp_rdata : bus[g].eng_rdata;
          nvec++;
          if (sbq[g].size() == 0) begin
            nmis++;
            $display("FAIL unexpected_rvalid inst%0d cyc %0d: got who=%0d data=%h, required no rvalid", g, cyc, who, data);
          end else begin
            e = sbq[g].pop_front();
            if (e.who != who || e.cyc != cyc || e.data !== data) begin
              nmis++;
              $display("FAIL rvalid inst%0d: got who=%0d cyc=%0d data=%h, required who=%0d cyc=%0d data=%h",
                       g, who, cyc, data, e.who, e.cyc, e.data);
            end
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s cyc %0d: got %h, required %h", nm, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int g, input int who, input int lat, input logic [31:0] d);
    exp_t e;
    e.who = who; e.cyc = cyc + lat; e.data = d;
    sbq[g].push_back(e);
  endtask

  task automatic idle_all();
    d_req = '0; e_req = '0; e_we = '0;
  endtask

  initial begin
    rst = '1;
    idle_all();
    for (int i = 0; i < N; i++) begin
      d_row[i] = '0; e_row[i] = '0; e_wd[i] = '0;
    end

    // Reset held with both requesters active
    d_req[0] = 1'b1; e_req[0] = 1'b1; d_row[0] = 5'd7; e_row[0] = 5'd3;
    repeat (2) begin
      step(); #1;
      chk("rst_dgnt", 32'(o_dgnt[0]), 0);
      chk("rst_egnt", 32'(o_egnt[0]), 0);
      chk("rst_mem_en", 32'(o_en[0]), 0);
      chk("rst_rvalid", 32'(o_drv[0] | o_erv[0]), 0);
    end

    // Contention: engine 8 cycles, then one forced display slot, repeating
    step(); rst = '0; #1;
    for (int k = 0; k < 27; k++) begin
      if (k > 0) begin step(); #1; end
      if (k % 9 == 8) begin
        chk("ctn_dgnt", 32'(o_dgnt[0]), 1);
        chk("ctn_egnt", 32'(o_egnt[0]), 0);
        chk("ctn_addr", 32'(o_addr[0]), 7);
        push(0, REQ_DISP, 1, init_val(0, 7));
      end else begin
        chk("ctn_dgnt", 32'(o_dgnt[0]), 0);
        chk("ctn_egnt", 32'(o_egnt[0]), 1);
        chk("ctn_addr", 32'(o_addr[0]), 3);
        push(0, REQ_ENG, 1, init_val(0, 3));
      end
    end
    step(); idle_all();
    repeat (3) step();

    // Display alone, row 5
    step(); d_req[0] = 1'b1; d_row[0] = 5'd5; #1;
    chk("disp_gnt", 32'(o_dgnt[0]), 1);
    chk("disp_addr", 32'(o_addr[0]), 5);
    chk("disp_mem_en", 32'(o_en[0]), 1);
    chk("disp_mem_we", 32'(o_we[0]), 0);
    push(0, REQ_DISP, 1, 32'hA5A5_0F0F);
    step(); d_req[0] = 1'b0; #1;
    chk("idle_mem_en", 32'(o_en[0]), 0);
    chk("idle_addr", 32'(o_addr[0]), 0);

    // Engine write then read of row 31
    step(); e_req[0] = 1'b1; e_we[0] = 1'b1; e_row[0] = 5'd31; e_wd[0] = 32'hDEAD_BEEF; #1;
    chk("wr_gnt", 32'(o_egnt[0]), 1);
    chk("wr_mem_we", 32'(o_we[0]), 1);
    chk("wr_addr", 32'(o_addr[0]), 31);
    chk("wr_wdata", o_wd[0], 32'hDEAD_BEEF);
    step(); e_we[0] = 1'b0; e_wd[0] = '0; #1;
    chk("rd_gnt", 32'(o_egnt[0]), 1);
    chk("rd_mem_we", 32'(o_we[0]), 0);
    chk("rd_addr", 32'(o_addr[0]), 31);
    push(0, REQ_ENG, 1, 32'hDEAD_BEEF);
    step(); idle_all(); #1;
    chk("idle_wdata", o_wd[0], 0);
    repeat (3) step();

    // READ_LATENCY=3: alternating display/engine reads
    for (int j = 0; j < 4; j++) begin
      step(); idle_all();
      if (j % 2 == 0) begin
        d_req[1] = 1'b1; d_row[1] = 5'(2 + j); #1;
        chk("rl3_dgnt", 32'(o_dgnt[1]), 1);
        push(1, REQ_DISP, 3, init_val(1, 2 + j));
      end else begin
        e_req[1] = 1'b1; e_row[1] = 5'(8 + j); #1;
        chk("rl3_egnt", 32'(o_egnt[1]), 1);
        push(1, REQ_ENG, 3, init_val(1, 8 + j));
      end
    end
    step(); idle_all();
    repeat (5) step();

    // READ_LATENCY=2: reset one cycle after a read grant kills its return
    step(); e_req[2] = 1'b1; e_row[2] = 5'd6; #1;
    chk("mid_egnt", 32'(o_egnt[2]), 1);
    step(); e_req[2] = 1'b0; rst[2] = 1'b1;
    step(); rst[2] = 1'b0;
    repeat (5) step();
    #1;
    chk("mid_no_rvalid", 32'(rv_cnt[2]), 0);
    step(); e_req[2] = 1'b1; #1;
    chk("post_rst_egnt", 32'(o_egnt[2]), 1);
    push(2, REQ_ENG, 2, init_val(2, 6));
    step(); idle_all();
    repeat (6) step();

    #1;
    for (int g = 0; g < N; g++) chk("sb_drained", 32'(sbq[g].size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
